// File: rtl/seg7_pkg.sv
// seg7_pkg -- shared types and constants for the two-digit 7-segment
// scan controller.
//   scan_state_t : scan FSM states (ones slot, blank, tens slot, blank)
//   bcd2_t       : two-digit BCD count {tens, ones}
//   SEG_0..SEG_9 : segment patterns, bit order g..a, active-high
//   SEG_BLANK    : all segments off
//   bcd2_step    : BCD up/down step with 99<->00 wrap
package seg7_pkg;

   typedef enum logic [1:0] {
      S_ONES   = 2'd0,
      S_BLANK1 = 2'd1,
      S_TENS   = 2'd2,
      S_BLANK2 = 2'd3
   } scan_state_t;

   typedef struct packed {
      logic [3:0] tens;
      logic [3:0] ones;
   } bcd2_t;

   localparam int TIMER_W = 10;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D; // tail on a
   localparam logic [6:0] SEG_7     = 7'h07; // a,b,c only
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F; // tail on d
   localparam logic [6:0] SEG_BLANK = 7'h00;

   // One count step; each digit stays in 0..9 and the pair wraps 99<->00.
   function automatic bcd2_t bcd2_step(input bcd2_t v, input logic up);
      bcd2_t r;
      r = v;
      if (up) begin
         if (v.ones == 4'd9) begin
            r.ones = 4'd0;
            r.tens = (v.tens == 4'd9) ? 4'd0 : v.tens + 4'd1;
         end else begin
            r.ones = v.ones + 4'd1;
         end
      end else begin
         if (v.ones == 4'd0) begin
            r.ones = 4'd9;
            r.tens = (v.tens == 4'd0) ? 4'd9 : v.tens - 4'd1;
         end else begin
            r.ones = v.ones - 4'd1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode -- combinational BCD to 7-segment decoder.
//   bcd : 4-bit BCD digit (codes 10..15 decode to blank)
//   seg : segments g..a, active-high
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl -- two-digit BCD up/down counter driving a multiplexed
// 7-segment display.
//   io_in[0]    clk, rising edge
//   io_in[1]    rst_n, asynchronous, active-low
//   io_in[2]    cnt_in, asynchronous count pulse (rising edge counts)
//   io_in[3]    up_dn, 1 = up, 0 = down
//   io_in[4]    clr, synchronous clear (wins over a count event)
//   io_in[5]    freeze, hold the displayed value
//   io_in[6]    lzb, blank a zero tens digit
//   io_in[7]    unused
//   io_out[6:0] segments g..a, registered
//   io_out[7]   dig_sel, 0 = ones, 1 = tens, registered
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int SCAN_DIV  = 8,
   parameter int BLANK_CYC = 1
) (
   input  logic [7:0] io_in,
   output logic [7:0] io_out
);

   localparam logic [TIMER_W-1:0] SHOW_LAST  = TIMER_W'(SCAN_DIV - 1);
   localparam logic [TIMER_W-1:0] BLANK_LAST = TIMER_W'(BLANK_CYC - 1);

   logic clk, rst_n, cnt_in, up_dn, clr, freeze, lzb, unused_io;

   assign clk       = io_in[0];
   assign rst_n     = io_in[1];
   assign cnt_in    = io_in[2];
   assign up_dn     = io_in[3];
   assign clr       = io_in[4];
   assign freeze    = io_in[5];
   assign lzb       = io_in[6];
   assign unused_io = io_in[7];

   // [0],[1] are the synchronizer, [2] is the previous synchronized value
   // used for rising-edge detection.
   logic [2:0] cnt_pipe;
   logic       cnt_evt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_pipe <= '0;
      else        cnt_pipe <= {cnt_pipe[1:0], cnt_in};
   end

   assign cnt_evt = cnt_pipe[1] & ~cnt_pipe[2];

   bcd2_t cnt_q, disp_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       cnt_q <= '0;
      else if (clr)     cnt_q <= '0;
      else if (cnt_evt) cnt_q <= bcd2_step(cnt_q, up_dn);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       disp_q <= '0;
      else if (!freeze) disp_q <= cnt_q;
   end

   scan_state_t        state;
   logic [TIMER_W-1:0] timer;
   logic [6:0]         seg_q;
   logic               dig_q;
   logic [3:0]         dec_in;
   logic [6:0]         dec_seg;
   logic               tens_blank;

   // Single decoder shared by both digits; the FSM state picks the digit.
   assign dec_in     = (state == S_TENS) ? disp_q.tens : disp_q.ones;
   assign tens_blank = lzb && (disp_q.tens == 4'd0);

   seg7_decode u_dec (
      .bcd (dec_in),
      .seg (dec_seg)
   );

   // Outputs are registered from the current state, so they trail the
   // FSM by one cycle. dig_sel is only written in show states and thus
   // holds through the blanking gaps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_ONES;
         timer <= '0;
         seg_q <= SEG_BLANK;
         dig_q <= 1'b0;
      end else begin
         case (state)
            S_ONES: begin
               seg_q <= dec_seg;
               dig_q <= 1'b0;
               if (timer == SHOW_LAST) begin
                  timer <= '0;
                  state <= S_BLANK1;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            S_BLANK1: begin
               seg_q <= SEG_BLANK;
               if (timer == BLANK_LAST) begin
                  timer <= '0;
                  state <= S_TENS;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            S_TENS: begin
               seg_q <= tens_blank ? SEG_BLANK : dec_seg;
               dig_q <= 1'b1;
               if (timer == SHOW_LAST) begin
                  timer <= '0;
                  state <= S_BLANK2;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            S_BLANK2: begin
               seg_q <= SEG_BLANK;
               if (timer == BLANK_LAST) begin
                  timer <= '0;
                  state <= S_ONES;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: begin
               state <= S_ONES;
               timer <= '0;
               seg_q <= SEG_BLANK;
            end
         endcase
      end
   end

   assign io_out = {dig_q, seg_q};

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl -- scoreboard bench for seg7_scan_ctrl. A reference
// model works from integer count arithmetic and the scan position within
// the period; it pushes the expected io_out per clock edge and a monitor
// pops and compares on the falling edge.
module tb_seg7_scan_ctrl;

   localparam int SD = 8;
   localparam int BC = 1;
   localparam int P  = 2 * (SD + BC);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic cnt_in = 1'b0, up_dn = 1'b0, clr = 1'b0, freeze = 1'b0, lzb = 1'b0;
   logic [7:0] io_in, io_out;

   assign io_in = {1'b0, lzb, freeze, clr, up_dn, cnt_in, rst_n, clk};

   seg7_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
      .io_in  (io_in),
      .io_out (io_out)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;
   logic [7:0] exp_q[$];

   function automatic logic [6:0] pat(input int d);
      case (d)
         0: return 7'b0111111;
         1: return 7'b0000110;
         2: return 7'b1011011;
         3: return 7'b1001111;
         4: return 7'b1100110;
         5: return 7'b1101101;
         6: return 7'b1111101;
         7: return 7'b0000111;
         8: return 7'b1111111;
         9: return 7'b1101111;
         default: return 7'b0000000;
      endcase
   endfunction

   // Reference model. h1..h3 hold cnt_in as sampled at the previous three
   // edges; a count takes effect two edges after the rise was first seen.
   int cnt_m = 0, disp_m = 0, n = 0;
   bit h1 = 0, h2 = 0, h3 = 0;

   always @(posedge clk) begin
      logic [7:0] e;
      int pos, t;
      if (!rst_n) begin
         cnt_m = 0; disp_m = 0; n = 0;
         h1 = 0; h2 = 0; h3 = 0;
         exp_q.push_back(8'h00);
      end else begin
         n++;
         pos = (n - 1) % P;
         t   = disp_m / 10;
         if (pos < SD)               e = {1'b0, pat(disp_m % 10)};
         else if (pos < SD + BC)     e = 8'h00;
         else if (pos < 2 * SD + BC) e = {1'b1, (lzb && t == 0) ? 7'h00 : pat(t)};
         else                        e = 8'h80;
         exp_q.push_back(e);
         if (!freeze) disp_m = cnt_m;
         if (clr)                cnt_m = 0;
         else if (h2 && !h3)     cnt_m = up_dn ? (cnt_m + 1) % 100 : (cnt_m + 99) % 100;
         h3 = h2; h2 = h1; h1 = cnt_in;
      end
   end

   // Monitor
   always @(negedge clk) begin
      logic [7:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (io_out === e) passes++;
         else $display("FAIL io_out t=%0t got=%h exp=%h", $time, io_out, e);
      end
   end

   task automatic step(input int k);
      repeat (k) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic pulse();
      cnt_in = 1'b1;
      step($urandom_range(1, 3));
      cnt_in = 1'b0;
      step($urandom_range(1, 3));
   endtask

   task automatic pulses(input int k);
      repeat (k) pulse();
   endtask

   initial begin
      bit found;
      step(3);
      rst_n = 1'b1;

      // idle scans, tens blanked then shown as 0
      lzb = 1'b1; step(2 * P);
      lzb = 1'b0; step(2 * P);

      // full up-count wrap
      up_dn = 1'b1;
      pulses(100);
      step(P);

      // down from 00 -> 99 -> 98
      up_dn = 1'b0;
      pulse(); step(P);
      pulse(); step(P);

      // clear colliding with a count event at 42
      clr = 1'b1; step(1); clr = 1'b0;
      up_dn = 1'b1;
      pulses(42); step(P);
      cnt_in = 1'b1; step(2);
      clr = 1'b1; step(1);
      clr = 1'b0; cnt_in = 1'b0;
      step(2 * P);

      // freeze at 17, count on to 22, release
      pulses(17); step(P);
      freeze = 1'b1;
      pulses(5); step(2 * P);
      freeze = 1'b0; step(2 * P);

      // reset in the middle of a tens slot at 55
      clr = 1'b1; step(1); clr = 1'b0;
      pulses(55); step(P);
      found = 0;
      for (int i = 0; i < 4 * P && !found; i++) begin
         @(negedge clk);
         if (io_out[7] && io_out[6:0] != 7'h00) found = 1;
      end
      checks++;
      if (found) passes++;
      else $display("FAIL tens_wait timeout io_out=%h exp=tens slot", io_out);
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (io_out === 8'h00) passes++;
      else $display("FAIL async_reset got=%h exp=00", io_out);
      step(3);
      rst_n = 1'b1;
      step(2 * P);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 2) == 0)  cnt_in = ~cnt_in;
         if ($urandom_range(0, 60) == 0) up_dn  = ~up_dn;
         if ($urandom_range(0, 80) == 0) freeze = ~freeze;
         if ($urandom_range(0, 50) == 0) lzb    = ~lzb;
         clr = ($urandom_range(0, 150) == 0);
         step(1);
      end
      clr = 1'b0;
      step(4);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
